// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, RV32I opcodes
// and branch func3 values. Decode imports the same package.
package ex_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_EQ   = 4'd10,
      ALU_NEQ  = 4'd11,
      ALU_GE   = 4'd12,
      ALU_GEU  = 4'd13,
      ALU_BUF  = 4'd14,
      ALU_ZERO = 4'd15
   } alu_op_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU. Comparison ops return 0 or 1; code 15 yields 0.
module ex_alu
   import ex_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [3:0]  ctrl_i,
   output logic [31:0] result_o
);

   logic [4:0] shamt;
   logic       ltSigned;
   logic       ltUnsigned;

   assign shamt      = b_i[4:0];
   assign ltSigned   = $signed(a_i) < $signed(b_i);
   assign ltUnsigned = a_i < b_i;

   always_comb begin
      result_o = '0;
      case (ctrl_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLL:  result_o = a_i << shamt;
         ALU_SLT:  result_o = {31'd0, ltSigned};
         ALU_SLTU: result_o = {31'd0, ltUnsigned};
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SRL:  result_o = a_i >> shamt;
         ALU_SRA:  result_o = $signed(a_i) >>> shamt;
         ALU_OR:   result_o = a_i | b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_EQ:   result_o = {31'd0, a_i == b_i};
         ALU_NEQ:  result_o = {31'd0, a_i != b_i};
         ALU_GE:   result_o = {31'd0, ~ltSigned};
         ALU_GEU:  result_o = {31'd0, ~ltUnsigned};
         ALU_BUF:  result_o = b_i;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand selection, ALU, branch resolution and jump
// targets, all captured in the EX/MEM register one cycle after sampling.
module ex_stage
   import ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   input  logic [31:0] i_imm_data,
   input  logic [31:0] i_pc,
   input  logic [3:0]  i_alu_ctrl,
   input  logic [2:0]  i_func3,
   input  logic [6:0]  i_opcode,
   output logic [31:0] o_result,
   output logic [31:0] o_data_store,
   output logic        o_boj,
   output logic        o_jalr,
   output logic [31:0] o_imm_data
);

   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] aluOut;
   logic [31:0] rs1PlusImm;
   logic [31:0] pcPlusImm;
   logic [31:0] pcPlus4;
   logic        branchTaken;

   logic [31:0] result_d, result_q;
   logic [31:0] store_q;
   logic        boj_d, boj_q;
   logic        jalr_d, jalr_q;
   logic [31:0] imm_d, imm_q;

   assign opA = (i_opcode == OP_AUIPC) ? i_pc : i_rs1_data;
   assign opB = ((i_opcode == OP_R) || (i_opcode == OP_B)) ? i_rs2_data : i_imm_data;

   ex_alu uAlu (
      .a_i      (opA),
      .b_i      (opB),
      .ctrl_i   (i_alu_ctrl),
      .result_o (aluOut)
   );

   assign rs1PlusImm = i_rs1_data + i_imm_data;
   assign pcPlusImm  = i_pc + i_imm_data;
   assign pcPlus4    = i_pc + 32'd4;

   // Branch comparator works on raw rs1/rs2 so the ALU code cannot skew it.
   always_comb begin
      branchTaken = 1'b0;
      case (i_func3)
         F3_BEQ:  branchTaken = (i_rs1_data == i_rs2_data);
         F3_BNE:  branchTaken = (i_rs1_data != i_rs2_data);
         F3_BLT:  branchTaken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
         F3_BGE:  branchTaken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
         F3_BLTU: branchTaken = (i_rs1_data <  i_rs2_data);
         F3_BGEU: branchTaken = (i_rs1_data >= i_rs2_data);
         default: branchTaken = 1'b0;
      endcase
   end

   always_comb begin
      result_d = '0;
      boj_d    = 1'b0;
      jalr_d   = 1'b0;
      imm_d    = i_imm_data;
      case (i_opcode)
         OP_R, OP_I, OP_LUI, OP_AUIPC: result_d = aluOut;
         OP_LD, OP_S:                  result_d = rs1PlusImm;
         OP_JAL: begin
            result_d = pcPlus4;
            boj_d    = 1'b1;
            imm_d    = pcPlusImm;
         end
         OP_JALR: begin
            result_d = pcPlus4;
            boj_d    = 1'b1;
            jalr_d   = 1'b1;
            imm_d    = rs1PlusImm & ~32'd1;
         end
         OP_B: begin
            boj_d = branchTaken;
            imm_d = pcPlusImm;
         end
         default: result_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         store_q  <= '0;
         boj_q    <= 1'b0;
         jalr_q   <= 1'b0;
         imm_q    <= '0;
      end else begin
         result_q <= result_d;
         store_q  <= i_rs2_data;
         boj_q    <= boj_d;
         jalr_q   <= jalr_d;
         imm_q    <= imm_d;
      end
   end

   assign o_result     = result_q;
   assign o_data_store = store_q;
   assign o_boj        = boj_q;
   assign o_jalr       = jalr_q;
   assign o_imm_data   = imm_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases, reset behaviour and
// randomized instructions compared against an arithmetic reference model.
module tb_ex_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] rs1, rs2, imm, pc;
   logic [3:0]  ctrl;
   logic [2:0]  func3;
   logic [6:0]  opcode;
   logic [31:0] result, dataStore, immOut;
   logic        boj, jalr;

   int testsRun  = 0;
   int testsFail = 0;

   ex_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rs1_data   (rs1),
      .i_rs2_data   (rs2),
      .i_imm_data   (imm),
      .i_pc         (pc),
      .i_alu_ctrl   (ctrl),
      .i_func3      (func3),
      .i_opcode     (opcode),
      .o_result     (result),
      .o_data_store (dataStore),
      .o_boj        (boj),
      .o_jalr       (jalr),
      .o_imm_data   (immOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                          S = 7'b0100011, B = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

   // Reference: evaluates one instruction straight from the ISA rules.
   function automatic void model(
      input  logic [31:0] mRs1, mRs2, mImm, mPc,
      input  logic [3:0]  mCtrl,
      input  logic [2:0]  mF3,
      input  logic [6:0]  mOp,
      output logic [31:0] eRes, eStore, eImm,
      output logic        eBoj, eJalr);
      longint a, b, sa, sb;
      logic [31:0] alu;
      int sh;
      bit taken;
      a  = (mOp == AUIPC) ? mPc : mRs1;
      b  = (mOp == R || mOp == B) ? mRs2 : mImm;
      sa = $signed(a[31:0]);
      sb = $signed(b[31:0]);
      sh = int'(b % 32);
      case (mCtrl)
         4'd0:  alu = 32'(a + b);
         4'd1:  alu = 32'(a - b);
         4'd2:  alu = 32'(a * (longint'(1) << sh));
         4'd3:  alu = (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  alu = (a < b) ? 32'd1 : 32'd0;
         4'd5:  alu = 32'(a) ^ 32'(b);
         4'd6:  alu = 32'(a / (longint'(1) << sh));
         4'd7:  alu = 32'(sa >>> sh);
         4'd8:  alu = 32'(a) | 32'(b);
         4'd9:  alu = 32'(a) & 32'(b);
         4'd10: alu = (a == b) ? 32'd1 : 32'd0;
         4'd11: alu = (a != b) ? 32'd1 : 32'd0;
         4'd12: alu = (sa >= sb) ? 32'd1 : 32'd0;
         4'd13: alu = (a >= b) ? 32'd1 : 32'd0;
         4'd14: alu = 32'(b);
         default: alu = 32'd0;
      endcase
      case (mF3)
         3'd0: taken = (mRs1 == mRs2);
         3'd1: taken = (mRs1 != mRs2);
         3'd4: taken = ($signed(mRs1) <  $signed(mRs2));
         3'd5: taken = ($signed(mRs1) >= $signed(mRs2));
         3'd6: taken = (mRs1 <  mRs2);
         3'd7: taken = (mRs1 >= mRs2);
         default: taken = 1'b0;
      endcase
      eStore = mRs2;
      eRes   = 32'd0;
      eImm   = mImm;
      eBoj   = 1'b0;
      eJalr  = (mOp == JALR);
      if (mOp == R || mOp == I || mOp == LUI || mOp == AUIPC) eRes = alu;
      if (mOp == LD || mOp == S) eRes = mRs1 + mImm;
      if (mOp == JAL || mOp == JALR) begin
         eRes = mPc + 32'd4;
         eBoj = 1'b1;
      end
      if (mOp == B) eBoj = taken;
      if (mOp == B || mOp == JAL) eImm = mPc + mImm;
      if (mOp == JALR) eImm = (mRs1 + mImm) & 32'hFFFF_FFFE;
   endfunction

   task automatic applyStimulus(input logic [31:0] aRs1, aRs2, aImm, aPc,
                                input logic [3:0] aCtrl, input logic [2:0] aF3,
                                input logic [6:0] aOp);
      @(negedge clk);
      rs1 = aRs1; rs2 = aRs2; imm = aImm; pc = aPc;
      ctrl = aCtrl; func3 = aF3; opcode = aOp;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] eRes, eStore,
                              input logic eBoj, eJalr, input logic [31:0] eImm);
      checkOne({tag, ".result"}, result, eRes);
      checkOne({tag, ".store"}, dataStore, eStore);
      checkOne({tag, ".boj"}, {31'd0, boj}, {31'd0, eBoj});
      checkOne({tag, ".jalr"}, {31'd0, jalr}, {31'd0, eJalr});
      checkOne({tag, ".imm"}, immOut, eImm);
   endtask

   initial begin
      logic [6:0]  opTable [10];
      logic [31:0] eRes, eStore, eImm;
      logic        eBoj, eJalr;
      logic [31:0] rRs1, rRs2, rImm, rPc;
      logic [3:0]  rCtrl;
      logic [2:0]  rF3;
      logic [6:0]  rOp;

      opTable = '{R, I, LD, S, B, JAL, JALR, LUI, AUIPC, 7'b1111111};

      // Inputs left undriven while reset is held.
      rst_n = 1'b0;
      #1;
      checkOutput("reset0", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      checkOutput("resetHeld", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'hABCDE123, 32'h98765432, 32'd0, 32'd0, 4'd0, 3'd0, R);
      checkOutput("rAdd", 32'h44443555, 32'h98765432, 1'b0, 1'b0, 32'd0);

      applyStimulus(32'hABCDEFAB, 32'h55, 32'd8, 32'd0, 4'd14, 3'b011, LD);
      checkOutput("load", 32'hABCDEFB3, 32'h55, 1'b0, 1'b0, 32'd8);

      applyStimulus(32'h12345678, 32'd0, 32'd4, 32'd0, 4'd14, 3'b010, S);
      checkOutput("store", 32'h1234567C, 32'd0, 1'b0, 1'b0, 32'd4);

      applyStimulus(32'hABCDEFAB, 32'hABCDEFAB, 32'd0, 32'd0, 4'd10, 3'b000, B);
      checkOutput("beqTaken", 32'd0, 32'hABCDEFAB, 1'b1, 1'b0, 32'd0);

      applyStimulus(32'hABCDEFAB, 32'hABCDEFAA, 32'd0, 32'd0, 4'd10, 3'b000, B);
      checkOutput("beqNot", 32'd0, 32'hABCDEFAA, 1'b0, 1'b0, 32'd0);

      // Reset dropped between edges must clear outputs without a clock.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRst", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      checkOutput("rstEdge", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rstRelease", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      applyStimulus(32'h2001, 32'h0, 32'd4, 32'h100, 4'd0, 3'b000, JALR);
      checkOutput("jalr", 32'h104, 32'h0, 1'b1, 1'b1, 32'h2004);

      applyStimulus(32'h0, 32'h7, 32'hFFFF_FFF0, 32'h200, 4'd0, 3'b000, JAL);
      checkOutput("jal", 32'h204, 32'h7, 1'b1, 1'b0, 32'h1F0);

      applyStimulus(32'h8000_0000, 32'h1, 32'd0, 32'h40, 4'd3, 3'b010, B);
      checkOutput("bNever", 32'd0, 32'h1, 1'b0, 1'b0, 32'h40);

      applyStimulus(32'h8000_0000, 32'h0, 32'd4, 32'h0, 4'd7, 3'b000, I);
      checkOutput("sra", 32'hF800_0000, 32'h0, 1'b0, 1'b0, 32'd4);

      for (int n = 0; n < 300; n++) begin
         rRs1  = $urandom;
         rRs2  = ($urandom_range(0, 3) == 0) ? rRs1 : $urandom;
         rImm  = $urandom;
         rPc   = $urandom;
         rCtrl = 4'($urandom_range(0, 15));
         rF3   = 3'($urandom_range(0, 7));
         rOp   = opTable[$urandom_range(0, 9)];
         applyStimulus(rRs1, rRs2, rImm, rPc, rCtrl, rF3, rOp);
         model(rRs1, rRs2, rImm, rPc, rCtrl, rF3, rOp, eRes, eStore, eImm, eBoj, eJalr);
         checkOutput($sformatf("rand%0d", n), eRes, eStore, eBoj, eJalr, eImm);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
